// File: rtl/calc_result_tx_pkg.sv
// Shared definitions for the calculator result formatter:
// state encodings and the ASCII bytes it emits.
package calc_result_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SIGN  = 3'd1,
        DIGIT = 3'd2,
        CR    = 3'd3,
        LF    = 3'd4
    } state_t;

    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_0     = 8'h30;
    localparam logic [7:0] ASC_A     = 8'h41;

endpackage

// File: rtl/calc_result_tx_if.sv
// Byte stream handshake from the formatter to the UART transmitter.
interface calc_result_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/calc_result_tx_nibble_ascii.sv
// Combinational 4-bit value to uppercase hex ASCII character.
import calc_result_tx_pkg::*;

module nibble_ascii (
    input  logic [3:0] nib,
    output logic [7:0] asc
);

    assign asc = (nib < 4'd10) ? (ASC_0 + {4'h0, nib})
                               : (ASC_A + {4'h0, nib} - 8'd10);

endmodule

// File: rtl/calc_result_tx.sv
// Streams one 32-bit calculator result as ASCII hex
// (optional '-', no leading zeros) followed by the line ending.
import calc_result_tx_pkg::*;

module calc_result_tx #(
    parameter bit SIGNED   = 1'b1,
    parameter bit EOL_CRLF = 1'b1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             calc_done,
    input  logic [31:0]      calc_res,
    calc_result_tx_if.master tx,
    output logic             busy,
    output logic             send_done,
    output logic             overrun
);

    state_t      state;
    logic [31:0] mag;
    logic [2:0]  dig_idx;

    logic        in_neg;
    logic [31:0] in_mag;
    logic [2:0]  in_idx;
    logic        xfer;

    logic [31:0] sel_word;
    logic [2:0]  sel_idx;
    logic [3:0]  nib;
    logic [7:0]  nib_asc;

    // 0x80000000 negates to itself, which still prints correctly as unsigned.
    assign in_neg = SIGNED && calc_res[31];
    assign in_mag = in_neg ? (~calc_res + 32'd1) : calc_res;
    assign xfer   = tx.tx_valid && tx.tx_ready;
    assign busy   = (state != IDLE);

    always_comb begin
        in_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (in_mag[4*i +: 4] != 4'h0) in_idx = i[2:0];
        end
    end

    // Nibble that becomes tx_data after the next state change.
    always_comb begin
        sel_word = mag;
        sel_idx  = dig_idx;
        if (state == IDLE) begin
            sel_word = in_mag;
            sel_idx  = in_idx;
        end else if (state == DIGIT) begin
            sel_idx = dig_idx - 3'd1;
        end
    end

    assign nib = 4'(sel_word >> {sel_idx, 2'b00});

    nibble_ascii u_nib (
        .nib (nib),
        .asc (nib_asc)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            mag        <= 32'h0;
            dig_idx    <= 3'd0;
            tx.tx_data <= 8'h00;
            tx.tx_valid <= 1'b0;
            send_done  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            send_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (calc_done) begin
                        mag         <= in_mag;
                        dig_idx     <= in_idx;
                        overrun     <= 1'b0;
                        tx.tx_valid <= 1'b1;
                        if (in_neg) begin
                            state      <= SIGN;
                            tx.tx_data <= ASC_MINUS;
                        end else begin
                            state      <= DIGIT;
                            tx.tx_data <= nib_asc;
                        end
                    end
                end
                SIGN: begin
                    if (xfer) begin
                        state      <= DIGIT;
                        tx.tx_data <= nib_asc;
                    end
                end
                DIGIT: begin
                    if (xfer) begin
                        if (dig_idx == 3'd0) begin
                            if (EOL_CRLF) begin
                                state      <= CR;
                                tx.tx_data <= ASC_CR;
                            end else begin
                                state      <= LF;
                                tx.tx_data <= ASC_LF;
                            end
                        end else begin
                            dig_idx    <= dig_idx - 3'd1;
                            tx.tx_data <= nib_asc;
                        end
                    end
                end
                CR: begin
                    if (xfer) begin
                        state      <= LF;
                        tx.tx_data <= ASC_LF;
                    end
                end
                LF: begin
                    if (xfer) begin
                        state       <= IDLE;
                        tx.tx_valid <= 1'b0;
                        send_done   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            if (calc_done && state != IDLE) overrun <= 1'b1;
        end
    end

endmodule
